de0_io_wing_ctrl: RTL and testbench

Parametrised multi-channel controller for the DE0 digital I/O wing's SN74LVC8T245 level-translator banks. It sits between user logic and the wing header pins. Per channel, it registers outbound data and synchronises inbound data. It also runs a break-before-make direction turnaround, so the FPGA and the translator never drive the same net. An optional change detector flags inbound activity.

---
 rtl/de0_io_wing_ctrl.sv | 164 ++++++++++++++++
 tb/tb_de0_io_wing_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/de0_io_wing_ctrl.sv
// de0_io_wing_ctrl: per-channel controller for the DE0 I/O wing SN74LVC8T245
// level-translator banks. Each channel registers outbound data, synchronises
// inbound data and runs a break-before-make direction turnaround so the FPGA
// and the translator never drive the same net at the same time.
//
// Optional feature: define WING_CHANGE_DETECT_EN to add the chg port, a
// one-cycle pulse per channel whenever the synchronised inbound data changes
// while the channel is settled in receive.
module de0_io_wing_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       dir_req,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       busy,
`ifdef WING_CHANGE_DETECT_EN
    output logic [CHANNELS-1:0]       chg,
`endif
    output logic [CHANNELS-1:0]       io_dir,
    output logic [CHANNELS-1:0]       oe_n,
    inout  wire  [CHANNELS*WIDTH-1:0] bus
);

    localparam int CW = $clog2(TURN_CYCLES + 1);
    localparam logic [CW-1:0] DWELL = CW'(TURN_CYCLES - 1);

    // OFF_* phases disable the translator with the old direction still set;
    // SW_* phases flip DIR while the translator is still disabled.
    typedef enum logic [2:0] {
        ST_RX,
        ST_TX,
        ST_OFF_RT,
        ST_SW_T,
        ST_OFF_TR,
        ST_SW_R
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state, state_nx;
        logic [CW-1:0]    cnt, cnt_nx;
        logic [WIDTH-1:0] out_q;
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];
        logic             drive, dir_c, oe_n_c, busy_c;

        // State and dwell-counter register; reset parks the channel in SW_R
        // with a full dwell so it settles into RX after TURN_CYCLES cycles.
        // NOTE: all flop state is updated with non-blocking assignments.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_SW_R;
                cnt   <= DWELL;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        // Next state: dir_req is only looked at in the settled states, so a
        // request that flips mid-turnaround is picked up on arrival.
        // NOTE: every output is defaulted first so no path infers a latch.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            unique case (state)
                ST_RX: if (dir_req[g]) begin
                    state_nx = ST_OFF_RT;
                    cnt_nx   = DWELL;
                end
                ST_TX: if (!dir_req[g]) begin
                    state_nx = ST_OFF_TR;
                    cnt_nx   = DWELL;
                end
                ST_OFF_RT, ST_SW_T, ST_OFF_TR, ST_SW_R: begin
                    if (cnt == '0) begin
                        cnt_nx = DWELL;
                        case (state)
                            ST_OFF_RT: state_nx = ST_SW_T;
                            ST_SW_T:   state_nx = ST_TX;
                            ST_OFF_TR: state_nx = ST_SW_R;
                            default:   state_nx = ST_RX;
                        endcase
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_SW_R;
                    cnt_nx   = DWELL;
                end
            endcase
        end

        // Pin decode: translator enabled only in a settled state, and the
        // FPGA drives the bus only in TX.
        always_comb begin
            drive  = 1'b0;
            dir_c  = 1'b0;
            oe_n_c = 1'b1;
            busy_c = 1'b1;
            unique case (state)
                ST_RX: begin
                    oe_n_c = !ch_en[g];
                    busy_c = 1'b0;
                end
                ST_TX: begin
                    dir_c  = 1'b1;
                    oe_n_c = !ch_en[g];
                    busy_c = 1'b0;
                    drive  = 1'b1;
                end
                ST_SW_T, ST_OFF_TR: dir_c = 1'b1;
                default: dir_c = 1'b0;
            endcase
        end

        // Outbound capture and inbound synchroniser, both every cycle.
        // NOTE: the synchroniser array is reset so in_data reads 0 in reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
                out_q     <= out_data[g*WIDTH +: WIDTH];
                sync_q[0] <= bus[g*WIDTH +: WIDTH];
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end

        assign bus[g*WIDTH +: WIDTH]     = drive ? out_q : {WIDTH{1'bz}};
        assign in_data[g*WIDTH +: WIDTH] = sync_q[SYNC_STAGES-1];
        assign io_dir[g]                 = dir_c;
        assign oe_n[g]                   = oe_n_c;
        assign busy[g]                   = busy_c;

`ifdef WING_CHANGE_DETECT_EN
        localparam int AW = $clog2(SYNC_STAGES + 1);
        logic [WIDTH-1:0] dly_q;
        logic [AW-1:0]    age_q;

        // Delay flop for edge detection plus a saturating age counter that
        // masks stale synchroniser contents right after entering RX.
        always_ff @(posedge clk) begin
            if (rst) begin
                dly_q <= '0;
                age_q <= '0;
            end else begin
                dly_q <= sync_q[SYNC_STAGES-1];
                if (state != ST_RX) age_q <= '0;
                else if (age_q != AW'(SYNC_STAGES)) age_q <= age_q + 1'b1;
            end
        end

        assign chg[g] = (state == ST_RX) && (age_q == AW'(SYNC_STAGES)) &&
                        (sync_q[SYNC_STAGES-1] != dly_q);
`endif
    end

endmodule

// File: tb/tb_de0_io_wing_ctrl.sv
// Bench for de0_io_wing_ctrl (CHANNELS=4, WIDTH=8, TURN_CYCLES=3,
// SYNC_STAGES=2): a directed vector table for the turnaround scenarios, an
// inbound latency sequence, and a randomized run compared every cycle
// against a timeline model of the turnaround.
module tb_de0_io_wing_ctrl;

    localparam int C = 4;
    localparam int W = 8;
    localparam int T = 3;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [C-1:0]   dir_req = '0;
    logic [C-1:0]   ch_en = '1;
    logic [C*W-1:0] out_data = 32'h0000_00A5;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   busy, io_dir, oe_n;
`ifdef WING_CHANGE_DETECT_EN
    logic [C-1:0]   chg;
`endif
    wire  [C*W-1:0] bus;
    logic [C*W-1:0] tb_bus_val = '0;
    logic [C-1:0]   tb_en = '1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < C; k++) begin : g_drv
        assign bus[k*W +: W] = tb_en[k] ? tb_bus_val[k*W +: W] : {W{1'bz}};
    end

    de0_io_wing_ctrl #(
        .CHANNELS(C), .WIDTH(W), .TURN_CYCLES(T), .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dir_req(dir_req),
        .ch_en(ch_en),
        .out_data(out_data),
        .in_data(in_data),
        .busy(busy),
`ifdef WING_CHANGE_DETECT_EN
        .chg(chg),
`endif
        .io_dir(io_dir),
        .oe_n(oe_n),
        .bus(bus)
    );

    // Timeline model: a channel is either settled in a direction, or in a
    // turnaround that began at edge m_entry; the first T cycles keep the old
    // direction, the next T the new one, and it settles at entry + 2T.
    int             cyc = 0;
    logic           m_in_turn [C];
    logic           m_settled [C];
    logic           m_to      [C];
    int             m_entry   [C];
    int             m_age     [C];
    logic [W-1:0]   m_outq    [C];
    logic [W-1:0]   m_hist    [C][S];
    logic [W-1:0]   m_prev_in [C];
    logic           prev_oe_n [C];
    logic           prev_dir  [C];
    logic           have_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_drive(int k);
        return !m_in_turn[k] && m_settled[k];
    endfunction

    task automatic model_edge();
        logic [W-1:0] smp;
        cyc++;
        for (int k = 0; k < C; k++) begin
            smp = m_drive(k) ? m_outq[k] : tb_bus_val[k*W +: W];
            if (rst) begin
                m_outq[k]    = '0;
                for (int i = 0; i < S; i++) m_hist[k][i] = '0;
                m_prev_in[k] = '0;
                m_in_turn[k] = 1'b1;
                m_to[k]      = 1'b0;
                m_settled[k] = 1'b0;
                m_entry[k]   = cyc - T;
                m_age[k]     = 0;
            end else begin
                m_prev_in[k] = m_hist[k][S-1];
                for (int i = S - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                m_hist[k][0] = smp;
                m_outq[k]    = out_data[k*W +: W];
                if (m_in_turn[k]) begin
                    if (cyc - m_entry[k] == 2 * T) begin
                        m_in_turn[k] = 1'b0;
                        m_settled[k] = m_to[k];
                        m_age[k]     = 0;
                    end
                end else if (dir_req[k] != m_settled[k]) begin
                    m_in_turn[k] = 1'b1;
                    m_to[k]      = dir_req[k];
                    m_entry[k]   = cyc;
                end else if (m_age[k] < S) begin
                    m_age[k]++;
                end
            end
        end
    endtask

    task automatic check_model();
        logic e_oe, e_dir, e_busy, e_chg, bad;
        for (int k = 0; k < C; k++) begin
            if (m_in_turn[k]) begin
                e_busy = 1'b1;
                e_oe   = 1'b1;
                e_dir  = (cyc - m_entry[k] < T) ? !m_to[k] : m_to[k];
            end else begin
                e_busy = 1'b0;
                e_oe   = !ch_en[k];
                e_dir  = m_settled[k];
            end
            check($sformatf("m_oe_n[%0d]@%0d", k, cyc), 64'(oe_n[k]), 64'(e_oe));
            check($sformatf("m_io_dir[%0d]@%0d", k, cyc), 64'(io_dir[k]), 64'(e_dir));
            check($sformatf("m_busy[%0d]@%0d", k, cyc), 64'(busy[k]), 64'(e_busy));
            check($sformatf("m_in_data[%0d]@%0d", k, cyc), 64'(in_data[k*W +: W]),
                  64'(m_hist[k][S-1]));
            check($sformatf("m_bus[%0d]@%0d", k, cyc), 64'(bus[k*W +: W]),
                  64'(m_drive(k) ? m_outq[k] : tb_bus_val[k*W +: W]));
`ifdef WING_CHANGE_DETECT_EN
            e_chg = !m_in_turn[k] && !m_settled[k] && (m_age[k] >= S) &&
                    (m_hist[k][S-1] != m_prev_in[k]);
            check($sformatf("m_chg[%0d]@%0d", k, cyc), 64'(chg[k]), 64'(e_chg));
`else
            e_chg = 1'b0;
`endif
            if (have_prev) begin
                bad = !prev_oe_n[k] && !oe_n[k] && (prev_dir[k] != io_dir[k]) && !e_chg;
                bad = bad | (!prev_oe_n[k] && !oe_n[k] && (prev_dir[k] != io_dir[k]));
                check($sformatf("dir_flip_while_oe[%0d]@%0d", k, cyc), 64'(bad), 64'(0));
            end
            prev_oe_n[k] = oe_n[k];
            prev_dir[k]  = io_dir[k];
        end
        have_prev = 1'b1;
    endtask

    // One clock: update the model from the inputs seen at the edge, release
    // or take the bus a moment later, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < C; k++) tb_en[k] = !m_drive(k);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        string      name;
        int         n;
        logic       rst;
        logic [3:0] dir;
        logic [3:0] en;
        logic [3:0] e_oe;
        logic [3:0] e_dir;
        logic [3:0] e_busy;
        logic       chk_bus;
        logic [7:0] e_bus0;
    } vec_t;

    vec_t vecs[16];

    initial begin
        for (int k = 0; k < C; k++) begin
            m_in_turn[k] = 1'b1; m_settled[k] = 1'b0; m_to[k] = 1'b0;
            m_entry[k] = 0; m_age[k] = 0; m_outq[k] = '0; m_prev_in[k] = '0;
            for (int i = 0; i < S; i++) m_hist[k][i] = '0;
        end

        vecs[0]  = '{"rst_hold",  5, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 8'h00};
        vecs[1]  = '{"rst_rel",   3, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00};
        vecs[2]  = '{"req_off",   1, 1'b0, 4'h9, 4'hF, 4'h9, 4'h0, 4'h9, 1'b0, 8'h00};
        vecs[3]  = '{"req_sw",    3, 1'b0, 4'h9, 4'hF, 4'h9, 4'h9, 4'h9, 1'b0, 8'h00};
        vecs[4]  = '{"req_tx",    3, 1'b0, 4'h9, 4'hF, 4'h0, 4'h9, 4'h0, 1'b1, 8'hA5};
        vecs[5]  = '{"dis_tx",    1, 1'b0, 4'h9, 4'h7, 4'h8, 4'h9, 4'h0, 1'b1, 8'hA5};
        vecs[6]  = '{"en_tx",     1, 1'b0, 4'h9, 4'hF, 4'h0, 4'h9, 4'h0, 1'b1, 8'hA5};
        vecs[7]  = '{"rev_off",   1, 1'b0, 4'hB, 4'hF, 4'h2, 4'h9, 4'h2, 1'b0, 8'h00};
        vecs[8]  = '{"rev_hold",  2, 1'b0, 4'hB, 4'hF, 4'h2, 4'h9, 4'h2, 1'b0, 8'h00};
        vecs[9]  = '{"rev_tx",    4, 1'b0, 4'h9, 4'hF, 4'h0, 4'hB, 4'h0, 1'b0, 8'h00};
        vecs[10] = '{"rev_offtr", 1, 1'b0, 4'h9, 4'hF, 4'h2, 4'hB, 4'h2, 1'b0, 8'h00};
        vecs[11] = '{"rev_rx",    6, 1'b0, 4'h9, 4'hF, 4'h0, 4'h9, 4'h0, 1'b0, 8'h00};
        vecs[12] = '{"rev_stay",  1, 1'b0, 4'h9, 4'hF, 4'h0, 4'h9, 4'h0, 1'b0, 8'h00};
        vecs[13] = '{"to_sw_t",   4, 1'b0, 4'hB, 4'hF, 4'h2, 4'hB, 4'h2, 1'b0, 8'h00};
        vecs[14] = '{"rst_sw_t",  1, 1'b1, 4'hB, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 8'h00};
        vecs[15] = '{"rst_back",  3, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00};

        for (int i = 0; i < 16; i++) begin
            rst     = vecs[i].rst;
            dir_req = vecs[i].dir;
            ch_en   = vecs[i].en;
            repeat (vecs[i].n) tick();
            check({vecs[i].name, "_oe_n"},   64'(oe_n),   64'(vecs[i].e_oe));
            check({vecs[i].name, "_io_dir"}, 64'(io_dir), 64'(vecs[i].e_dir));
            check({vecs[i].name, "_busy"},   64'(busy),   64'(vecs[i].e_busy));
            if (vecs[i].chk_bus)
                check({vecs[i].name, "_bus0"}, 64'(bus[7:0]), 64'(vecs[i].e_bus0));
        end

        // Inbound latency on channel 2, settled in RX well past the mask.
        repeat (3) tick();
        tb_bus_val[23:16] = 8'h3C;
        tick();
        check("in_lat_1", 64'(in_data[23:16]), 64'h00);
        tick();
        check("in_lat_2", 64'(in_data[23:16]), 64'h3C);
`ifdef WING_CHANGE_DETECT_EN
        check("chg2_pulse", 64'(chg[2]), 64'h1);
`endif
        tick();
        check("in_lat_hold", 64'(in_data[23:16]), 64'h3C);
`ifdef WING_CHANGE_DETECT_EN
        check("chg2_single", 64'(chg[2]), 64'h0);
`endif

        // Randomized traffic against the timeline model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < C; k++) begin
                if ($urandom_range(0, 19) == 0) dir_req[k] = !dir_req[k];
                ch_en[k] = ($urandom_range(0, 9) != 0);
            end
            out_data = $urandom;
            if ($urandom_range(0, 3) == 0) tb_bus_val = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
